pll_underclock_seq: RTL
=======================

Name: pll_underclock_seq

Overview:
- Sequencer that drives the Avalon-MM management port of the Altera PLL reconfiguration IP.
- Toggles the video/system PLL between the native and the ~1% underclocked ("60Hz Adjust") fractional-K setting when the OSD bit changes.
- Sits between the OSD status word (synchronised here) and the pll_cfg instance.
- Waits for PLL relock and reports which setting is actually applied, so the core's sound-timing compensation follows the real clock, not the request.

Parameters:
- K_NATIVE, 32'd3639383488, fractional-K value written for the native clock.
- K_UNDER, 32'd3268298314, fractional-K value written for the underclocked setting.
- STABLE_CYCLES, 4, consecutive equal synchronised samples required before a request is accepted.
- UNLOCK_WAIT, 1024, maximum cycles to wait for pll_locked to fall after the start write.
- LOCK_TIMEOUT, 65535, maximum cycles to wait for pll_locked to rise again.

Ports:
- clk_sys, in, 1, management clock (CLK_50M domain).
- reset, in, 1, asynchronous, active-high reset.
- underclock_req, in, 1, requested mode (status[21]); asynchronous to clk_sys.
- cfg_waitrequest, in, 1, Avalon waitrequest from pll_cfg.
- pll_locked, in, 1, PLL locked flag; asynchronous, 2-flop synchronised internally.
- cfg_write, out, 1, Avalon write strobe.
- cfg_address, out, 6, Avalon address.
- cfg_data, out, 32, Avalon write data.
- busy, out, 1, high while a reconfiguration is in progress.
- underclock_active, out, 1, mode last successfully applied.
- cfg_error, out, 1, sticky lock-timeout flag.

Behaviour:
- Reset values: cfg_write=0, cfg_address=0, cfg_data=0, busy=0, underclock_active=0 (PLL power-up config is native), cfg_error=0, state=IDLE, all counters cleared.
- Request filtering:
  - underclock_req goes through a 2-flop synchroniser.
  - The stability counter counts consecutive cycles with an unchanged synchronised value. It saturates at STABLE_CYCLES and restarts at 1 on any change.
  - A request is "pending" when the counter equals STABLE_CYCLES and the value differs from underclock_active.
- IDLE: if pending, latch target <= synchronised value, set busy=1, go to WR_MODE.
  - target is fixed for the rest of the sequence; request changes during a sequence are re-evaluated only back in IDLE.
- Avalon write rule, used by WR_MODE, WR_K and WR_START:
  - Drive cfg_write=1 with stable address/data.
  - Hold while cfg_waitrequest=1.
  - The transfer completes on the first cycle with cfg_write=1 and cfg_waitrequest=0.
  - Next cycle: cfg_write=0, with at least one idle cycle before the next write.
  - cfg_write is never high for 2 cycles when waitrequest is low.
- WR_MODE: address 0, data 0 (waitrequest mode) -> WR_K.
- WR_K: address 7, data = target ? K_UNDER : K_NATIVE -> WR_START.
- WR_START: address 2, data 0 -> WAIT_UNLOCK, counter cleared.
- WAIT_UNLOCK: leave when synchronised locked = 0, or when the counter reaches UNLOCK_WAIT-1 (a fast relock may be missed). Clear the counter and go to WAIT_LOCK.
- WAIT_LOCK:
  - When synchronised locked = 1: underclock_active <= target, busy <= 0, go to IDLE.
  - If the counter reaches LOCK_TIMEOUT-1 first: cfg_error <= 1, underclock_active <= target (the PLL registers now hold target), busy <= 0, go to IDLE.
- cfg_error clears only on reset.
- Asynchronous reset mid-sequence forces all reset values immediately, including dropping cfg_write during a waitrequest stall. After reset the block assumes native; if the request is 1, a fresh full sequence runs.
- Back-to-back: a request toggled 1 then 0 during a sequence for 1 produces a second full sequence for 0 after return to IDLE. It needs STABLE_CYCLES already satisfied, so the second sequence starts on the IDLE cycle.
- Counters: width is clog2(LOCK_TIMEOUT+1); no wrap-around within a state.

Test Plan:
- Reset, req=0 held 100 cycles, waitrequest=0 -> no cfg_write ever; busy=0, underclock_active=0.
- req 0->1, waitrequest=0, locked drops 5 cycles after the WR_START write and rises 20 cycles later -> exactly 3 single-cycle writes: (0,0), (7,3268298314), (2,0), each separated by ≥1 idle cycle. underclock_active=1 one cycle after synchronised locked=1; busy=0 then.
- Same as above but waitrequest high for 7 cycles during the K write -> cfg_write, address 7 and data held for 8 cycles; write completes once.
- 1-cycle glitch pulse on req (STABLE_CYCLES=4) -> no sequence started.
- req 0->1, locked never falls or rises, LOCK_TIMEOUT=200 -> cfg_error=1, underclock_active=1, busy=0 after UNLOCK_WAIT+200 cycles past WR_START.
- Reset asserted while cfg_write=1 stalled in WR_K -> cfg_write=0 asynchronously. After release with req=1, a full 3-write sequence to K_UNDER.
- req toggled 1->0 during WAIT_LOCK -> first sequence completes (active=1), then a second sequence writes K_NATIVE (3639383488), ending with active=0.

Source files
------------

// File: rtl/pll_underclock_seq.sv
// Avalon-MM sequencer that retunes the PLL fractional-K between native and ~1% underclocked.
// Reports the applied mode only after the PLL relocks (or the lock wait times out).
module pll_underclock_seq #(
  parameter logic [31:0] K_NATIVE      = 32'd3639383488,
  parameter logic [31:0] K_UNDER       = 32'd3268298314,
  parameter int          STABLE_CYCLES = 4,
  parameter int          UNLOCK_WAIT   = 1024,
  parameter int          LOCK_TIMEOUT  = 65535
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        underclock_req,
  input  logic        cfg_waitrequest,
  input  logic        pll_locked,
  output logic        cfg_write,
  output logic [5:0]  cfg_address,
  output logic [31:0] cfg_data,
  output logic        busy,
  output logic        underclock_active,
  output logic        cfg_error
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > UNLOCK_WAIT) ? LOCK_TIMEOUT : UNLOCK_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  UNLOCK_LAST = CNT_W'(UNLOCK_WAIT - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(STABLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_K,
    S_WR_START,
    S_WAIT_UNLOCK,
    S_WAIT_LOCK
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         req_sync_q;
  logic [1:0]         lock_sync_q;
  logic               req_prev_q;
  logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic               target_q, target_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_write_q, cfg_write_d;
  logic [5:0]         cfg_address_q, cfg_address_d;
  logic [31:0]        cfg_data_q, cfg_data_d;
  logic               busy_q, busy_d;
  logic               active_q, active_d;
  logic               error_q, error_d;

  logic req_s, lock_s, pending, wr_done;

  assign req_s   = req_sync_q[1];
  assign lock_s  = lock_sync_q[1];
  assign wr_done = cfg_write_q && !cfg_waitrequest;
  // req_prev_q is the value stab_cnt_q has been counting.
  assign pending = (stab_cnt_q == STAB_MAX) && (req_prev_q != active_q);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_sync_q    <= 2'b00;
      lock_sync_q   <= 2'b00;
      req_prev_q    <= 1'b0;
      stab_cnt_q    <= '0;
      target_q      <= 1'b0;
      cnt_q         <= '0;
      cfg_write_q   <= 1'b0;
      cfg_address_q <= 6'd0;
      cfg_data_q    <= 32'd0;
      busy_q        <= 1'b0;
      active_q      <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_sync_q    <= {req_sync_q[0], underclock_req};
      lock_sync_q   <= {lock_sync_q[0], pll_locked};
      req_prev_q    <= req_s;
      stab_cnt_q    <= stab_cnt_d;
      target_q      <= target_d;
      cnt_q         <= cnt_d;
      cfg_write_q   <= cfg_write_d;
      cfg_address_q <= cfg_address_d;
      cfg_data_q    <= cfg_data_d;
      busy_q        <= busy_d;
      active_q      <= active_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (req_s != req_prev_q) begin
      stab_cnt_d = STAB_W'(1);
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (pending) state_d = S_WR_MODE;
      S_WR_MODE:     if (wr_done) state_d = S_WR_K;
      S_WR_K:        if (wr_done) state_d = S_WR_START;
      S_WR_START:    if (wr_done) state_d = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: if (!lock_s || cnt_q == UNLOCK_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK:   if (lock_s || cnt_q == LOCK_LAST) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  logic        in_wr;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    target_d      = target_q;
    cnt_d         = cnt_q;
    cfg_write_d   = cfg_write_q;
    cfg_address_d = cfg_address_q;
    cfg_data_d    = cfg_data_q;
    busy_d        = busy_q;
    active_d      = active_q;
    error_d       = error_q;
    in_wr         = 1'b0;
    wr_addr       = 6'd0;
    wr_data       = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (pending) begin
          target_d = req_prev_q;
          busy_d   = 1'b1;
        end
      end
      S_WR_MODE: begin
        in_wr   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 32'd0;
      end
      S_WR_K: begin
        in_wr   = 1'b1;
        wr_addr = 6'd7;
        wr_data = target_q ? K_UNDER : K_NATIVE;
      end
      S_WR_START: begin
        in_wr   = 1'b1;
        wr_addr = 6'd2;
        wr_data = 32'd0;
        if (wr_done) cnt_d = '0;
      end
      S_WAIT_UNLOCK: begin
        if (!lock_s || cnt_q == UNLOCK_LAST) cnt_d = '0;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          active_d = target_q;
          busy_d   = 1'b0;
        end else if (cnt_q == LOCK_LAST) begin
          // PLL registers already hold target, so report it even without lock.
          error_d  = 1'b1;
          active_d = target_q;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // Write strobe rises only from low, giving an idle cycle between transfers.
    if (in_wr) begin
      if (!cfg_write_q) begin
        cfg_write_d   = 1'b1;
        cfg_address_d = wr_addr;
        cfg_data_d    = wr_data;
      end else if (!cfg_waitrequest) begin
        cfg_write_d = 1'b0;
      end
    end
  end

  assign cfg_write         = cfg_write_q;
  assign cfg_address       = cfg_address_q;
  assign cfg_data          = cfg_data_q;
  assign busy              = busy_q;
  assign underclock_active = active_q;
  assign cfg_error         = error_q;

endmodule
